seq_alu: RTL

Parametrised, registered successor to the team's combinational 8-bit ALU. It performs add, subtract, AND, OR, NOT and XOR in one cycle, and signed or unsigned multiplication over WIDTH+1 cycles with an iterative shift-add datapath. A start/busy/done handshake drives it, and results and flags are held until the next accepted operation. It sits between the operand registers and the writeback stage of the datapath.

---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_alu_ks_adder.sv | 57 +++++
 rtl/seq_alu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MULU = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bits needed for the iteration counter (and the number of prefix levels).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_alu_ks_adder.sv
// Parametrised Kogge-Stone prefix adder with carry-in, carry-out and signed overflow.
module ks_adder
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overflowFlag
);

    localparam int LV = cnt_w(WIDTH);

    logic [WIDTH-1:0] half_sum;
    logic [WIDTH-1:0] g_pre;
    logic [WIDTH-1:0] p_pre;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH:0]   carry;

    assign half_sum = A ^ B;

    // Prefix tree: level l combines each bit with the group 2^l positions below it.
    always_comb begin
        g_pre = A & B;
        p_pre = A ^ B;
        g_nxt = '0;
        p_nxt = '0;
        for (int l = 0; l < LV; l++) begin
            g_nxt = g_pre;
            p_nxt = p_pre;
            for (int i = (1 << l); i < WIDTH; i++) begin
                g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
                p_nxt[i] = p_pre[i] & p_pre[i - (1 << l)];
            end
            g_pre = g_nxt;
            p_pre = p_nxt;
        end
    end

    // Carry into each bit from the group generate/propagate over [i:0] and Cin.
    always_comb begin
        carry    = '0;
        carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_pre[i] | (p_pre[i] & Cin);
        end
    end

    assign S            = half_sum ^ carry[WIDTH-1:0];
    assign Cout         = carry[WIDTH];
    assign overflowFlag = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle add/sub/logic ops, WIDTH-cycle shift-add multiply.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; single-cycle ops commit on acceptance
// ST_MUL  | shift-add iterations, busy high; commits on counter == 0
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           S,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   O,
    output logic                 zeroFlag,
    output logic                 carryFlag,
    output logic                 signFlag,
    output logic                 overflowFlag
);

    localparam int CW = cnt_w(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam logic [W2-1:0] ONE_2W = {{(W2-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [W2-1:0]   o_q, o_d;
    logic            zero_q, zero_d;
    logic            carry_q, carry_d;
    logic            sign_q, sign_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mpl_q, mpl_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;

    logic            op_sub;
    logic            op_mul_s;
    logic            in_mul;

    logic [WIDTH-1:0] as_a, as_b, as_sum;
    logic            as_cin, as_cout, as_ovf;
    logic [WIDTH-1:0] mul_a, mul_b, mul_sum;
    logic            mul_cin, mul_cout, mul_ovf_unused;

    logic [WIDTH-1:0] alu_res;
    logic            alu_c, alu_v;
    logic [W2-1:0]   prod_raw;
    logic [W2-1:0]   prod_fin;

    assign op_sub   = (S == OP_SUB);
    assign op_mul_s = (S == OP_MUL);
    assign in_mul   = (state_q == ST_MUL);

    // In IDLE this adder also produces |B| (0 + ~B + 1) for a signed multiply.
    assign as_a   = op_mul_s ? '0 : A;
    assign as_b   = (op_sub || op_mul_s) ? ~B : B;
    assign as_cin = op_sub || op_mul_s;

    ks_adder #(.WIDTH(WIDTH)) u_add_sub (
        .A            (as_a),
        .B            (as_b),
        .Cin          (as_cin),
        .S            (as_sum),
        .Cout         (as_cout),
        .overflowFlag (as_ovf)
    );

    // Accumulate adder while iterating; negates A (0 + ~A + 1) on multiply entry.
    assign mul_a   = in_mul ? acc_q : '0;
    assign mul_b   = in_mul ? (mpl_q[0] ? mcand_q : '0) : ~A;
    assign mul_cin = ~in_mul;

    ks_adder #(.WIDTH(WIDTH)) u_mul_acc (
        .A            (mul_a),
        .B            (mul_b),
        .Cin          (mul_cin),
        .S            (mul_sum),
        .Cout         (mul_cout),
        .overflowFlag (mul_ovf_unused)
    );

    // Final-iteration product is {carry, sum, multiplier >> 1}; sign applied on commit.
    assign prod_raw = {mul_cout, mul_sum, mpl_q[WIDTH-1:1]};
    assign prod_fin = neg_q ? (~prod_raw + ONE_2W) : prod_raw;

    // Single-cycle result and flags for the non-multiply opcodes.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (S)
            OP_ADD, OP_SUB: begin
                alu_res = as_sum;
                alu_c   = as_cout;
                alu_v   = as_ovf;
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOT:  alu_res = ~A;
            OP_XOR:  alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    // Next-state, datapath and commit logic.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        mpl_d   = mpl_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (S == OP_MUL || S == OP_MULU) begin
                        state_d = ST_MUL;
                        mpl_d   = (op_mul_s && A[WIDTH-1]) ? mul_sum : A;
                        mcand_d = (op_mul_s && B[WIDTH-1]) ? as_sum : B;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        neg_d   = op_mul_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                    end else begin
                        o_d     = {{WIDTH{1'b0}}, alu_res};
                        zero_d  = ~|alu_res;
                        carry_d = alu_c;
                        sign_d  = alu_res[WIDTH-1];
                        ovf_d   = alu_v;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d = {mul_cout, mul_sum[WIDTH-1:1]};
                mpl_d = {mul_sum[0], mpl_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    o_d     = prod_fin;
                    zero_d  = ~|prod_fin;
                    carry_d = 1'b0;
                    sign_d  = prod_fin[W2-1];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            o_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            mpl_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            mpl_q   <= mpl_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign busy         = in_mul;
    assign done         = done_q;
    assign O            = o_q;
    assign zeroFlag     = zero_q;
    assign carryFlag    = carry_q;
    assign signFlag     = sign_q;
    assign overflowFlag = ovf_q;

endmodule
